// File: rtl/sprite_pixel_reader.sv
// Sprite read client: turns the VGA scan position into map/character RAM reads and
// composites the character over the map, one palette index per clock, 3-cycle latency.
module sprite_pixel_reader #(
    parameter int unsigned MAP_W       = 1024,
    parameter int unsigned MAP_H       = 1152,
    parameter int unsigned CHAR_W      = 19,
    parameter int unsigned CHAR_H      = 29,
    parameter int unsigned CHAR_FRAMES = 12,
    parameter int unsigned TRANSP_IDX  = 0,
    parameter int unsigned BORDER_IDX  = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_start,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        draw_en,
    input  logic [10:0] cam_x,
    input  logic [10:0] cam_y,
    input  logic [9:0]  char_x,
    input  logic [9:0]  char_y,
    input  logic [3:0]  char_frame,
    output logic [20:0] map_read_address,
    output logic [12:0] char_read_address,
    input  logic [4:0]  map_data,
    input  logic [4:0]  char_data,
    output logic [4:0]  pix_index,
    output logic        pix_valid
);

    typedef enum logic {WAIT_FRAME, RUN} state_t;

    state_t      state;
    logic [10:0] cam_x_s, cam_y_s;
    logic [9:0]  char_x_s, char_y_s;
    logic [3:0]  frame_s;

    logic        s1_go, map_hit, chr_hit;
    logic [11:0] wx, wy;
    logic [10:0] rx, ry;
    logic [20:0] map_addr;
    logic [12:0] char_addr;

    logic        v1, mi1, ci1;
    logic        v2, mi2, ci2;

    // Hit flags are gated by the stage valid so idle or pre-frame cycles read address 0.
    always_comb begin
        s1_go     = draw_en && (state == RUN);
        wx        = {1'b0, cam_x_s} + {2'b0, DrawX};
        wy        = {1'b0, cam_y_s} + {2'b0, DrawY};
        rx        = {1'b0, DrawX} - {1'b0, char_x_s};
        ry        = {1'b0, DrawY} - {1'b0, char_y_s};
        map_hit   = s1_go && (32'(wx) < MAP_W) && (32'(wy) < MAP_H);
        chr_hit   = s1_go && !rx[10] && !ry[10]
                    && (32'(rx[9:0]) < CHAR_W) && (32'(ry[9:0]) < CHAR_H);
        map_addr  = 21'(21'(wy) * 21'(MAP_W) + 21'(wx));
        char_addr = 13'(13'(frame_s) * 13'(CHAR_W * CHAR_H)
                    + 13'(ry[9:0]) * 13'(CHAR_W) + 13'(rx[9:0]));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state             <= WAIT_FRAME;
            cam_x_s           <= '0;
            cam_y_s           <= '0;
            char_x_s          <= '0;
            char_y_s          <= '0;
            frame_s           <= '0;
            v1                <= 1'b0;
            mi1               <= 1'b0;
            ci1               <= 1'b0;
            v2                <= 1'b0;
            mi2               <= 1'b0;
            ci2               <= 1'b0;
            map_read_address  <= '0;
            char_read_address <= '0;
            pix_index         <= '0;
            pix_valid         <= 1'b0;
        end else begin
            if (frame_start) begin
                state    <= RUN;
                cam_x_s  <= cam_x;
                cam_y_s  <= cam_y;
                char_x_s <= char_x;
                char_y_s <= char_y;
                frame_s  <= (32'(char_frame) >= CHAR_FRAMES) ? '0 : char_frame;
            end

            v1                <= s1_go;
            mi1               <= map_hit;
            ci1               <= chr_hit;
            map_read_address  <= map_hit ? map_addr : '0;
            char_read_address <= chr_hit ? char_addr : '0;

            v2  <= v1;
            mi2 <= mi1;
            ci2 <= ci1;

            pix_valid <= v2;
            if (!v2)
                pix_index <= '0;
            else if (ci2 && (char_data != 5'(TRANSP_IDX)))
                pix_index <= char_data;
            else if (mi2)
                pix_index <= map_data;
            else
                pix_index <= 5'(BORDER_IDX);
        end
    end

endmodule

// File: tb/tb_sprite_pixel_reader.sv
// Directed bench for sprite_pixel_reader: per-cycle reference model feeds a scoreboard
// queue of expected pixels; addresses are checked one cycle after each drive.
module tb_sprite_pixel_reader;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        frame_start = 1'b0;
    logic [9:0]  DrawX = '0, DrawY = '0;
    logic        draw_en = 1'b0;
    logic [10:0] cam_x = '0, cam_y = '0;
    logic [9:0]  char_x = '0, char_y = '0;
    logic [3:0]  char_frame = '0;
    logic [20:0] map_read_address;
    logic [12:0] char_read_address;
    logic [4:0]  map_data = '0, char_data = '0;
    logic [4:0]  pix_index;
    logic        pix_valid;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       v;
        logic [4:0] pix;
    } exp_t;
    exp_t q[$];

    // reference state
    bit m_run = 0;
    int m_cx = 0, m_cy = 0, m_chx = 0, m_chy = 0, m_fr = 0;
    bit force_en = 0;
    logic [4:0] force_val = '0;

    sprite_pixel_reader #(
        .MAP_W(1024), .MAP_H(1152), .CHAR_W(19), .CHAR_H(29),
        .CHAR_FRAMES(12), .TRANSP_IDX(0), .BORDER_IDX(0)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .draw_en(draw_en),
        .cam_x(cam_x), .cam_y(cam_y), .char_x(char_x), .char_y(char_y),
        .char_frame(char_frame),
        .map_read_address(map_read_address), .char_read_address(char_read_address),
        .map_data(map_data), .char_data(char_data),
        .pix_index(pix_index), .pix_valid(pix_valid)
    );

    always #5 Clk = ~Clk;

    function automatic logic [4:0] mapf(input logic [20:0] a);
        return a[4:0] ^ a[9:5] ^ a[14:10] ^ a[19:15];
    endfunction

    function automatic logic [4:0] charf(input logic [12:0] a);
        return a[4:0] + a[9:5] + {2'b0, a[12:10]};
    endfunction

    // registered-read RAM models
    always @(posedge Clk) begin
        map_data  <= mapf(map_read_address);
        char_data <= force_en ? force_val : charf(char_read_address);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        int wx, wy, rx, ry, ma, ca;
        bit v, mi, ci;
        logic [4:0] md, cd;
        exp_t e;
        if (Reset) begin
            q.delete();
            e.v = 1'b0;
            e.pix = '0;
            repeat (3) q.push_back(e);
            ma = 0;
            ca = 0;
            m_run = 0;
            m_cx = 0; m_cy = 0; m_chx = 0; m_chy = 0; m_fr = 0;
        end else begin
            v  = draw_en && m_run;
            wx = m_cx + int'(DrawX);
            wy = m_cy + int'(DrawY);
            rx = int'(DrawX) - m_chx;
            ry = int'(DrawY) - m_chy;
            mi = v && wx < 1024 && wy < 1152;
            ci = v && rx >= 0 && rx < 19 && ry >= 0 && ry < 29;
            ma = mi ? wy * 1024 + wx : 0;
            ca = ci ? m_fr * 551 + ry * 19 + rx : 0;
            md = mapf(21'(ma));
            cd = force_en ? force_val : charf(13'(ca));
            e.v = v;
            e.pix = !v ? 5'd0 : (ci && cd != 0) ? cd : mi ? md : 5'd0;
            q.push_back(e);
            if (frame_start) begin
                m_run = 1;
                m_cx = int'(cam_x); m_cy = int'(cam_y);
                m_chx = int'(char_x); m_chy = int'(char_y);
                m_fr = (char_frame >= 12) ? 0 : int'(char_frame);
            end
        end
        @(posedge Clk);
        #1;
        check("map_addr", 32'(map_read_address), 32'(ma));
        check("char_addr", 32'(char_read_address), 32'(ca));
        if (q.size() == 3) begin
            e = q.pop_front();
            check("pix_valid", 32'(pix_valid), 32'(e.v));
            check("pix_index", 32'(pix_index), 32'(e.pix));
        end
    endtask

    task automatic idle(input int n);
        draw_en = 1'b0;
        frame_start = 1'b0;
        repeat (n) cyc();
    endtask

    task automatic px(input int x, input int y);
        DrawX = 10'(x);
        DrawY = 10'(y);
        draw_en = 1'b1;
        cyc();
    endtask

    task automatic fs(input int cx, input int cy, input int chx, input int chy, input int fr);
        cam_x = 11'(cx); cam_y = 11'(cy);
        char_x = 10'(chx); char_y = 10'(chy);
        char_frame = 4'(fr);
        draw_en = 1'b0;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    initial begin
        // reset, then visible pixels with no frame_start yet
        Reset = 1'b1;
        cyc();
        cyc();
        check("reset_pix_valid", 32'(pix_valid), 32'd0);
        check("reset_pix_index", 32'(pix_index), 32'd0);
        Reset = 1'b0;
        for (int i = 0; i < 100; i++) px($urandom_range(0, 639), $urandom_range(0, 479));
        check("wait_pix_valid", 32'(pix_valid), 32'd0);
        idle(3);

        // camera offset, character parked off-screen
        fs(100, 50, 900, 500, 0);
        px(3, 2);
        check("tp_map_addr", 32'(map_read_address), 32'd53351);
        for (int x = 0; x < 40; x++) px(x, 2);
        idle(3);

        // character composite at frame 2
        fs(0, 0, 10, 20, 2);
        force_en = 1; force_val = 5'd7;
        px(12, 21);
        check("tp_char_addr", 32'(char_read_address), 32'd1123);
        idle(3);
        check("tp_char_pix", 32'(pix_index), 32'd0);
        force_val = 5'd0;
        px(12, 21);
        idle(3);
        force_en = 0;
        for (int x = 5; x < 36; x++) px(x, 21);
        for (int y = 18; y < 52; y++) px(15, y);
        idle(3);

        // right map edge: wx past MAP_W gives border
        fs(1020, 0, 900, 400, 0);
        px(2, 0);
        px(3, 0);
        px(5, 0);
        check("tp_edge_addr", 32'(map_read_address), 32'd0);
        px(4, 1151);
        fs(0, 1140, 900, 400, 0);
        for (int y = 8; y < 16; y++) px(7, y);
        idle(3);

        // shadow inputs change without frame_start; then out-of-range frame select
        fs(200, 10, 50, 50, 1);
        cam_x = 11'd700; char_x = 10'd0; char_frame = 4'd15;
        for (int x = 48; x < 60; x++) px(x, 55);
        fs(0, 0, 0, 0, 15);
        px(1, 1);
        check("tp_frame0_addr", 32'(char_read_address), 32'd20);
        idle(3);

        // frame_start landing mid-stream
        for (int x = 0; x < 10; x++) begin
            if (x == 4) begin
                cam_x = 11'd300; cam_y = 11'd30; char_x = 10'd3; char_y = 10'd0;
                char_frame = 4'd11;
                frame_start = 1'b1;
            end
            px(x, 5);
            frame_start = 1'b0;
        end
        idle(3);

        // reset during a streaming line
        for (int x = 0; x < 6; x++) px(x + 100, 9);
        Reset = 1'b1;
        px(106, 9);
        check("rst_mid_pix_valid", 32'(pix_valid), 32'd0);
        Reset = 1'b0;
        for (int x = 0; x < 20; x++) px(x, 9);
        fs(40, 40, 20, 20, 5);
        for (int x = 15; x < 45; x++) px(x, 25);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
